// File: rtl/op_sel_pipe.sv
// D->X pipeline register producing ALU operand and store/branch data selects,
// with forwarding from up to FWD_STAGES downstream producers and load-use detection.
module op_sel_pipe #(
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      d_inst,
  input  logic             d_valid,
  output logic [31:0]      x_inst,
  output logic             x_valid,
  output logic [SEL_W-1:0] x_a_sel,
  output logic [SEL_W-1:0] x_b_sel,
  output logic [SEL_W-1:0] x_rs2_sel,
  output logic             load_use
);

  localparam logic [6:0]  OpLui    = 7'h37;
  localparam logic [6:0]  OpAuipc  = 7'h17;
  localparam logic [6:0]  OpJal    = 7'h6f;
  localparam logic [6:0]  OpJalr   = 7'h67;
  localparam logic [6:0]  OpBranch = 7'h63;
  localparam logic [6:0]  OpLoad   = 7'h03;
  localparam logic [6:0]  OpStore  = 7'h23;
  localparam logic [6:0]  OpArithI = 7'h13;
  localparam logic [6:0]  OpArith  = 7'h33;
  localparam logic [31:0] Nop      = 32'h0000_0013;

  typedef struct packed {
    logic       valid;
    logic       wen;
    logic       is_load;
    logic [4:0] rd;
  } hist_t;

  hist_t hist_q [FWD_STAGES];
  hist_t hist_d [FWD_STAGES];
  hist_t hist_in;

  logic [31:0]      x_inst_q, x_inst_d;
  logic             x_valid_q, x_valid_d;
  logic [SEL_W-1:0] a_sel_q, a_sel_d;
  logic [SEL_W-1:0] b_sel_q, b_sel_d;
  logic [SEL_W-1:0] rs2_sel_q, rs2_sel_d;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic       wen, uses_rs1, uses_rs2, uses_pc, is_arith, is_load;

  assign opcode = d_inst[6:0];
  assign rd     = d_inst[11:7];
  assign rs1    = d_inst[19:15];
  assign rs2    = d_inst[24:20];

  always_comb begin
    wen      = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    uses_pc  = 1'b0;
    is_arith = 1'b0;
    is_load  = 1'b0;
    case (opcode)
      OpLui:    wen = 1'b1;
      OpAuipc:  begin wen = 1'b1; uses_pc = 1'b1; end
      OpJal:    begin wen = 1'b1; uses_pc = 1'b1; end
      OpJalr:   begin wen = 1'b1; uses_rs1 = 1'b1; end
      OpBranch: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; uses_pc = 1'b1; end
      OpLoad:   begin wen = 1'b1; uses_rs1 = 1'b1; is_load = 1'b1; end
      OpStore:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OpArithI: begin wen = 1'b1; uses_rs1 = 1'b1; end
      OpArith:  begin wen = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_arith = 1'b1; end
      default:  ;
    endcase
  end

  // Scan oldest to youngest so the youngest producer overwrites older matches.
  logic [SEL_W-1:0] rs1_fwd, rs2_fwd;
  always_comb begin
    rs1_fwd = '0;
    rs2_fwd = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (hist_q[k].valid && hist_q[k].wen && rs1 != 5'd0 && hist_q[k].rd == rs1) begin
        rs1_fwd = SEL_W'(k + 2);
      end
      if (hist_q[k].valid && hist_q[k].wen && rs2 != 5'd0 && hist_q[k].rd == rs2) begin
        rs2_fwd = SEL_W'(k + 2);
      end
    end
  end

  logic m0_rs1, m0_rs2;
  assign m0_rs1 = hist_q[0].valid && hist_q[0].wen && rs1 != 5'd0 && hist_q[0].rd == rs1;
  assign m0_rs2 = hist_q[0].valid && hist_q[0].wen && rs2 != 5'd0 && hist_q[0].rd == rs2;

  assign load_use = d_valid && hist_q[0].is_load &&
                    ((m0_rs1 && uses_rs1) || (m0_rs2 && uses_rs2));

  always_comb begin
    x_inst_d  = x_inst_q;
    x_valid_d = x_valid_q;
    a_sel_d   = a_sel_q;
    b_sel_d   = b_sel_q;
    rs2_sel_d = rs2_sel_q;
    hist_d    = hist_q;
    hist_in   = '0;
    if (flush || (!stall && !d_valid)) begin
      x_inst_d  = Nop;
      x_valid_d = 1'b0;
      a_sel_d   = '0;
      b_sel_d   = '0;
      rs2_sel_d = '0;
    end else if (!stall) begin
      x_inst_d  = d_inst;
      x_valid_d = 1'b1;
      a_sel_d   = uses_pc ? SEL_W'(1) : (uses_rs1 ? rs1_fwd : '0);
      b_sel_d   = is_arith ? rs2_fwd : SEL_W'(1);
      rs2_sel_d = (uses_rs2 && !is_arith) ? rs2_fwd : '0;
      hist_in   = '{valid: d_valid, wen: wen, is_load: is_load, rd: rd};
    end
    // A flush still ages the history, pushing an empty slot.
    if (flush || !stall) begin
      hist_d[0] = hist_in;
      for (int k = 1; k < FWD_STAGES; k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_inst_q  <= Nop;
      x_valid_q <= 1'b0;
      a_sel_q   <= '0;
      b_sel_q   <= '0;
      rs2_sel_q <= '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      x_inst_q  <= x_inst_d;
      x_valid_q <= x_valid_d;
      a_sel_q   <= a_sel_d;
      b_sel_q   <= b_sel_d;
      rs2_sel_q <= rs2_sel_d;
      for (int k = 0; k < FWD_STAGES; k++) begin
        hist_q[k] <= hist_d[k];
      end
    end
  end

  assign x_inst    = x_inst_q;
  assign x_valid   = x_valid_q;
  assign x_a_sel   = a_sel_q;
  assign x_b_sel   = b_sel_q;
  assign x_rs2_sel = rs2_sel_q;

endmodule
